// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 128-byte data memory.
// Each granted transaction runs IDLE -> ACCESS (LATENCY cycles) -> RESP, or IDLE -> RESP on a range error.
module dmem_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LATENCY   = 2,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  // Handshake: a requester raises req with we/addr/wdata and holds them stable
  // until its done pulse; done (with err) is high for exactly one cycle and the
  // requester drops req in that cycle. req seen again in IDLE is a new transaction.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                id_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                last_grant;

  logic                gnt_valid;
  logic                gnt_id;
  logic                gnt_we;
  logic                gnt_bad;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt_valid = m0_req | m1_req;
    if (m0_req && m1_req) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = m1_req;
    end
    gnt_we    = gnt_id ? m1_we    : m0_we;
    gnt_addr  = gnt_id ? m1_addr  : m0_addr;
    gnt_wdata = gnt_id ? m1_wdata : m0_wdata;
    gnt_bad   = (gnt_addr > MAX_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt = gnt_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= 1'b1;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (state == IDLE && gnt_valid) begin
        id_q       <= gnt_id;
        we_q       <= gnt_we;
        addr_q     <= gnt_addr;
        wdata_q    <= gnt_wdata;
        err_q      <= gnt_bad;
        last_grant <= gnt_id;
        cnt        <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!we_q) begin
          if (id_q) begin
            m1_rdata <= mem_data_out;
          end else begin
            m0_rdata <= mem_data_out;
          end
        end
      end
    end
  end

  // The write strobe is confined to the final ACCESS cycle so memory sees one edge.
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    m0_done     = 1'b0;
    m1_done     = 1'b0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    busy        = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_address = addr_q;
        mem_data_in = wdata_q;
        mem_read    = ~we_q;
        mem_write   = we_q && (cnt == 4'd0);
      end
      RESP: begin
        m0_done = ~id_q;
        m1_done = id_q;
        m0_err  = ~id_q & err_q;
        m1_err  = id_q & err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, reference model of memory contents,
// per-port read data and grant history, directed plus randomized transactions.
module tb_dmem_arbiter;

  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b0;
  logic rst4_n   = 1'b0;
  logic load_mem = 1'b1;

  // ---------------- DUT (LATENCY=2) ----------------
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [63:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [63:0] m0_rdata, m1_rdata, mem_address, mem_data_in, mem_data_out;
  logic        m0_done, m0_err, m1_done, m1_err, mem_read, mem_write, busy;

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .LATENCY(LAT), .MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_data_out(mem_data_out), .busy(busy)
  );

  // ---------------- DUT (LATENCY=4), used for the reset-mid-access case ----------------
  logic        a4_req = 0, a4_we = 0, z4_req = 0, z4_we = 0;
  logic [63:0] a4_addr = 0, a4_wdata = 0, z4_addr = 0, z4_wdata = 0;
  logic [63:0] a4_rdata, z4_rdata, mem_address4, mem_data_in4, mem_data_out4;
  logic        a4_done, a4_err, z4_done, z4_err, mem_read4, mem_write4, busy4;

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .LATENCY(LAT4), .MEM_BYTES(128)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .m0_req(a4_req), .m0_we(a4_we), .m0_addr(a4_addr), .m0_wdata(a4_wdata),
    .m0_rdata(a4_rdata), .m0_done(a4_done), .m0_err(a4_err),
    .m1_req(z4_req), .m1_we(z4_we), .m1_addr(z4_addr), .m1_wdata(z4_wdata),
    .m1_rdata(z4_rdata), .m1_done(z4_done), .m1_err(z4_err),
    .mem_address(mem_address4), .mem_data_in(mem_data_in4), .mem_read(mem_read4),
    .mem_write(mem_write4), .mem_data_out(mem_data_out4), .busy(busy4)
  );

  // ---------------- memories: combinational read, posedge write ----------------
  logic [7:0] mem  [0:127];
  logic [7:0] mem4 [0:127];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) begin
        mem[i]  <= 8'(i);
        mem4[i] <= 8'(i);
      end
    end else begin
      if (mem_write && mem_address <= 64'd120)
        for (int i = 0; i < 8; i++) mem[int'(mem_address[6:0]) + i] <= mem_data_in[8*i +: 8];
      if (mem_write4 && mem_address4 <= 64'd120)
        for (int i = 0; i < 8; i++) mem4[int'(mem_address4[6:0]) + i] <= mem_data_in4[8*i +: 8];
    end
  end

  always_comb begin
    mem_data_out  = '0;
    mem_data_out4 = '0;
    if (mem_address <= 64'd120)
      for (int i = 0; i < 8; i++) mem_data_out[8*i +: 8] = mem[int'(mem_address[6:0]) + i];
    if (mem_address4 <= 64'd120)
      for (int i = 0; i < 8; i++) mem_data_out4[8*i +: 8] = mem4[int'(mem_address4[6:0]) + i];
  end

  // ---------------- monitors ----------------
  int cyc = 0, rd_cyc = 0, wr_cyc = 0, wr4_cyc = 0, dbl = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_read)            rd_cyc  <= rd_cyc + 1;
    if (mem_write)           wr_cyc  <= wr_cyc + 1;
    if (mem_write4)          wr4_cyc <= wr4_cyc + 1;
    if (m0_done && m1_done)  dbl     <= dbl + 1;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [0:127];
  logic [63:0] rd_model [2];
  int          last_m;
  logic [63:0] exp_q[$];
  int          port_q[$];
  int          checks = 0, errors = 0;

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a[6:0]) + i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic req, input logic we,
                       input logic [63:0] a, input logic [63:0] d);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Single-port transaction; called at #1 after a posedge with the DUT in IDLE.
  task automatic run_txn(input int p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata);
    logic        exp_err, got;
    logic [63:0] exp_rd, exp_other;
    int          exp_lat, lat, rd0, wr0;
    exp_err   = (addr > 64'd120);
    exp_lat   = exp_err ? 2 : LAT + 2;
    exp_rd    = (!we && !exp_err) ? ref_rd(addr) : rd_model[p];
    exp_other = rd_model[1-p];
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    drive(p, 1'b1, we, addr, wdata);
    lat = 1;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = (p == 1) ? m1_done : m0_done;
    end
    check("done_seen", got, 1);
    check("latency", lat, exp_lat);
    check("err", (p == 1) ? m1_err : m0_err, exp_err);
    check("other_done", (p == 1) ? m0_done : m1_done, 0);
    check("rdata", (p == 1) ? m1_rdata : m0_rdata, exp_rd);
    check("busy_resp", busy, 1);
    drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("busy_idle", busy, 0);
    check("other_rdata", (p == 1) ? m0_rdata : m1_rdata, exp_other);
    check("rd_cycles", rd_cyc - rd0, (!we && !exp_err) ? LAT : 0);
    check("wr_cycles", wr_cyc - wr0, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err)
      for (int i = 0; i < 8; i++) ref_mem[int'(addr[6:0]) + i] = wdata[8*i +: 8];
    rd_model[p] = exp_rd;
    last_m      = p;
  endtask

  // Both ports keep requesting reads; grants must alternate, spaced LAT+2 cycles.
  task automatic fair_test();
    logic [63:0] a [6];
    int          o [6];
    int          first, nxt, prev, p, ep;
    logic        got;
    first = 1 - last_m;
    for (int k = 0; k < 6; k++) begin
      o[k] = (first + k) % 2;
      a[k] = 64'($urandom_range(0, 120));
      exp_q.push_back(ref_rd(a[k]));
      port_q.push_back(o[k]);
    end
    drive(o[0], 1'b1, 1'b0, a[0], 64'd0);
    drive(o[1], 1'b1, 1'b0, a[1], 64'd0);
    nxt  = 2;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(posedge clk); #1;
        got = m0_done | m1_done;
      end
      check("fair_done_seen", got, 1);
      if (!got) break;
      p  = m1_done ? 1 : 0;
      ep = port_q.pop_front();
      check("fair_port", p, ep);
      rd_model[p] = exp_q.pop_front();
      check("fair_rdata", (p == 1) ? m1_rdata : m0_rdata, rd_model[p]);
      if (k > 0) check("fair_spacing", cyc - prev, LAT + 2);
      prev   = cyc;
      last_m = p;
      if (nxt < 6) begin
        drive(p, 1'b1, 1'b0, a[nxt], 64'd0);
        nxt++;
      end else begin
        drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
      end
    end
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    port_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] exp4, got4;
    logic        got;
    int          lat;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
    rd_model[0] = '0;
    rd_model[1] = '0;
    last_m      = 1;

    @(posedge clk); #1;
    load_mem = 1'b0;
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_m0_done", m0_done, 0);
    check("rst_m1_done", m1_done, 0);
    check("rst_m0_err", m0_err, 0);
    check("rst_m1_err", m1_err, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 1'b0, 64'h10, 64'd0);
    run_txn(1, 1'b1, 64'h20, 64'hDEADBEEFCAFEF00D);
    run_txn(0, 1'b0, 64'h20, 64'd0);
    fair_test();
    run_txn(0, 1'b0, 64'h79, 64'd0);
    run_txn(0, 1'b0, 64'h78, 64'd0);
    run_txn(1, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd0);

    for (int n = 0; n < 14; n++) begin
      int          p;
      logic        we;
      logic [63:0] a;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(121, 255))
                                        : 64'($urandom_range(0, 120));
      run_txn(p, we, a, {$urandom, $urandom});
    end

    // LATENCY=4 instance: reset lands in the second ACCESS cycle of a write.
    a4_req = 1'b1; a4_we = 1'b1; a4_addr = 64'h08; a4_wdata = {$urandom, $urandom};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst4_busy_before", busy4, 1);
    rst4_n = 1'b0;
    #1;
    check("rst4_busy", busy4, 0);
    check("rst4_mem_write", mem_write4, 0);
    check("rst4_mem_read", mem_read4, 0);
    check("rst4_mem_address", mem_address4, 0);
    check("rst4_mem_data_in", mem_data_in4, 0);
    check("rst4_done", {z4_done, a4_done}, 0);
    check("rst4_err", {z4_err, a4_err}, 0);
    check("rst4_rdata", a4_rdata | z4_rdata, 0);
    a4_req = 1'b0; a4_we = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b1;
    check("rst4_no_write", wr4_cyc, 0);
    exp4 = '0;
    for (int i = 0; i < 8; i++) begin
      exp4[8*i +: 8] = 8'(8 + i);
      got4[8*i +: 8] = mem4[8 + i];
    end
    check("rst4_mem_bytes", got4, exp4);
    @(posedge clk); #1;
    a4_req = 1'b1; a4_we = 1'b0; a4_addr = 64'h08;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = a4_done;
    end
    check("r4_done_seen", got, 1);
    check("r4_latency", lat, LAT4 + 2);
    check("r4_err", a4_err, 0);
    check("r4_rdata", a4_rdata, exp4);
    a4_req = 1'b0;
    @(posedge clk); #1;
    check("r4_busy_idle", busy4, 0);

    check("no_double_done", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
